// File: rtl/ifu_imem_rsp.sv
// ifu_imem_rsp
// ------------
// Instruction-memory responder for the IFetch CMD/RSP protocol. Fetch PCs
// arrive on the CMD channel. Each accepted PC reads one word from an on-block
// synchronous instruction RAM. The word goes into a 2-entry in-order response
// FIFO, which drives the RSP channel together with an error flag. A separate
// loader write port fills the RAM with program images.
//
// Handshake: a channel transfers on a rising edge where valid & ready are
// both 1. A source holds valid and its payload stable until that edge. The
// sink's ready never depends combinationally on the same channel's valid.
// o_cmd_ready depends only on the registered FIFO count.
//
// Ports
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-high reset
//   i_cmd_valid  in   fetch request valid
//   o_cmd_ready  out  fetch request accepted when valid & ready
//   i_cmd_pc     in   fetch byte address (AW)
//   o_rsp_valid  out  response valid (FIFO head present)
//   i_rsp_ready  in   response consumed when valid & ready
//   o_rsp_err    out  response error (misaligned or out of range)
//   o_rsp_instr  out  instruction word (DW), 0 on error or when empty
//   i_wr_en      in   loader write strobe
//   i_wr_addr    in   loader byte address (AW)
//   i_wr_data    in   loader data (DW)

module ifu_imem_rsp #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW-1:0] i_cmd_pc,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic          o_rsp_err,
    output logic [DW-1:0] o_rsp_instr,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data
);

    localparam int             IW        = $clog2(MEM_WORDS);
    // One extra bit so the byte size of the RAM can never overflow AW.
    localparam logic [AW:0]    MEM_BYTES = (AW+1)'(MEM_WORDS) << 2;

    logic [DW-1:0] mem [MEM_WORDS];

    // Response FIFO storage and control.
    logic          fifo_err  [2];
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    count;
    logic          head;
    logic          tail;

    // Fetch address decode.
    logic [AW-1:0] cmd_offset;
    logic          cmd_err;
    logic [IW-1:0] cmd_idx;

    // Loader address decode.
    logic [AW-1:0] wr_offset;
    logic          wr_ok;
    logic [IW-1:0] wr_idx;

    logic          cmd_fire;
    logic          rsp_fire;

    // Subtraction wraps modulo 2^AW. A PC below BASE_ADDR therefore becomes a
    // huge offset and fails the range check.
    assign cmd_offset = i_cmd_pc - BASE_ADDR;
    assign cmd_err    = (i_cmd_pc[1:0] != 2'b00) || ({1'b0, cmd_offset} >= MEM_BYTES);
    assign cmd_idx    = cmd_offset[IW+1:2];

    assign wr_offset  = i_wr_addr - BASE_ADDR;
    assign wr_ok      = i_wr_en && (i_wr_addr[1:0] == 2'b00) &&
                        ({1'b0, wr_offset} < MEM_BYTES);
    assign wr_idx     = wr_offset[IW+1:2];

    assign o_cmd_ready = (count != 2'd2);
    assign o_rsp_valid = (count != 2'd0);
    assign o_rsp_err   = o_rsp_valid ? fifo_err[head]  : 1'b0;
    assign o_rsp_instr = o_rsp_valid ? fifo_data[head] : '0;

    assign cmd_fire = i_cmd_valid && o_cmd_ready;
    assign rsp_fire = o_rsp_valid && i_rsp_ready;

    // A push happens only when count < 2, so the free slot is next to head
    // when one entry is held and at head when the FIFO is empty. On a
    // simultaneous push and pop at count 1, this is the slot that becomes the
    // new head.
    assign tail = head ^ count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            case ({cmd_fire, rsp_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (rsp_fire) begin
                head <= ~head;
            end
        end
    end

    // The RAM and FIFO payload are not reset. The FIFO count alone decides
    // what is visible. The read uses the pre-edge array contents, so a write
    // and a fetch to the same word on the same edge returns the old data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= i_wr_data;
        end
        if (cmd_fire) begin
            fifo_err[tail]  <= cmd_err;
            fifo_data[tail] <= cmd_err ? '0 : mem[cmd_idx];
        end
    end

endmodule

// File: tb/tb_ifu_imem_rsp.sv
module tb_ifu_imem_rsp;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
    logic [31:0] cmd_pc, rsp_instr, wr_addr, wr_data;

    // Second instance with a non-zero base address.
    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_wr_en;
    logic [31:0] b_cmd_pc, b_rsp_instr, b_wr_addr, b_wr_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

    ifu_imem_rsp u_dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_pc(cmd_pc),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_err(rsp_err), .o_rsp_instr(rsp_instr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    ifu_imem_rsp #(.BASE_ADDR(32'h8000_0000)) u_hi (
        .clk(clk), .rst(rst),
        .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready), .i_cmd_pc(b_cmd_pc),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_err(b_rsp_err), .o_rsp_instr(b_rsp_instr),
        .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_pc = '0; rsp_ready = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        b_cmd_valid = 0; b_cmd_pc = '0; b_rsp_ready = 0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_instr, cmd_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b e=%b i=%h rdy=%b, want v=0 e=0 i=0 rdy=1",
                     rsp_valid, rsp_err, rsp_instr, cmd_ready);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 32'(i * 4); wr_data = prog[i];
            tick();
        end
        wr_en = 0;
        // Seed word 4 (0x10) for the collision test.
        wr_en = 1; wr_addr = 32'h10; wr_data = 32'h1111_1111;
        tick();
        wr_en = 0;
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1;
        for (int i = 0; i <= 4; i++) begin
            cmd_valid = (i < 4);
            cmd_pc    = 32'(i * 4);
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, cmd_ready);
            end
            if (i > 0) begin
                checks++;
                if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, 1'b0, prog[i-1]}) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: got v=%b e=%b i=%h want v=1 e=0 i=%h",
                             i - 1, rsp_valid, rsp_err, rsp_instr, prog[i-1]);
                end
            end
            tick();
        end
        cmd_valid = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        cmd_valid = 1; cmd_pc = 32'h0;
        tick();
        checks++;
        if ({rsp_valid, rsp_instr, cmd_ready} !== {1'b1, prog[0], 1'b1}) begin
            errors++;
            $display("FAIL bp_first: got v=%b i=%h rdy=%b want v=1 i=%h rdy=1",
                     rsp_valid, rsp_instr, cmd_ready, prog[0]);
        end
        cmd_pc = 32'h4;
        tick();
        cmd_pc = 32'h8;
        checks++;
        if ({cmd_ready, rsp_instr} !== {1'b0, prog[0]}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b i=%h want rdy=0 i=%h", cmd_ready, rsp_instr, prog[0]);
        end
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_instr} !== {1'b0, 1'b1, prog[0]}) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b v=%b i=%h want rdy=0 v=1 i=%h",
                     cmd_ready, rsp_valid, rsp_instr, prog[0]);
        end
        rsp_ready = 1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_instr} !== {1'b1, 1'b1, prog[1]}) begin
            errors++;
            $display("FAIL bp_pop1: got rdy=%b v=%b i=%h want rdy=1 v=1 i=%h",
                     cmd_ready, rsp_valid, rsp_instr, prog[1]);
        end
        tick();
        cmd_valid = 0;
        checks++;
        if ({rsp_valid, rsp_instr} !== {1'b1, prog[2]}) begin
            errors++;
            $display("FAIL bp_third: got v=%b i=%h want v=1 i=%h", rsp_valid, rsp_instr, prog[2]);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_errors();
        logic [31:0] pcs    [4] = '{32'h4, 32'h2, 32'h1000, 32'hC};
        logic        e_err  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_data [4] = '{32'h0010_0093, 32'h0, 32'h0, 32'h0030_0193};
        rsp_ready = 1;
        for (int i = 0; i <= 4; i++) begin
            cmd_valid = (i < 4);
            cmd_pc    = (i < 4) ? pcs[i] : 32'h0;
            if (i > 0) begin
                checks++;
                if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, e_err[i-1], e_data[i-1]}) begin
                    errors++;
                    $display("FAIL err_rsp[%0d]: got v=%b e=%b i=%h want v=1 e=%b i=%h",
                             i - 1, rsp_valid, rsp_err, rsp_instr, e_err[i-1], e_data[i-1]);
                end
            end
            tick();
        end
        cmd_valid = 0;
        tick();
    endtask

    task automatic test_wr_collision();
        rsp_ready = 1;
        wr_en = 1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF;
        cmd_valid = 1; cmd_pc = 32'h10;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, 1'b0, 32'h1111_1111}) begin
            errors++;
            $display("FAIL wr_same_edge: got v=%b e=%b i=%h want v=1 e=0 i=11111111",
                     rsp_valid, rsp_err, rsp_instr);
        end
        // Misaligned write must not touch word 4.
        wr_addr = 32'h11; wr_data = 32'h5555_5555;
        tick();
        wr_en = 0;
        checks++;
        if (rsp_instr !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_new_data: got %h want deadbeef", rsp_instr);
        end
        tick();
        cmd_valid = 0;
        checks++;
        if (rsp_instr !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_misaligned_ignored: got %h want deadbeef", rsp_instr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 0;
        cmd_valid = 1; cmd_pc = 32'h0;
        tick();
        cmd_pc = 32'h4;
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full: got rdy=%b want 0", cmd_ready);
        end
        rst = 1;
        tick();
        rst = 0;
        cmd_valid = 0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_instr, cmd_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_state: got v=%b e=%b i=%h rdy=%b want v=0 e=0 i=0 rdy=1",
                     rsp_valid, rsp_err, rsp_instr, cmd_ready);
        end
        // A command accepted on the reset edge must not produce a response.
        cmd_valid = 1; cmd_pc = 32'h8; rst = 1;
        tick();
        rst = 0; cmd_valid = 0; rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_rsp[%0d]: got v=%b want 0", i, rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_base();
        b_wr_en = 1; b_wr_addr = 32'h8000_0004; b_wr_data = 32'hCAFE_F00D;
        tick();
        b_wr_en = 0;
        b_rsp_ready = 1;
        b_cmd_valid = 1; b_cmd_pc = 32'h8000_0004;
        tick();
        b_cmd_pc = 32'h7FFF_FFFC;
        checks++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_instr} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL base_in_range: got v=%b e=%b i=%h want v=1 e=0 i=cafef00d",
                     b_rsp_valid, b_rsp_err, b_rsp_instr);
        end
        tick();
        b_cmd_valid = 0;
        checks++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_instr} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL base_below: got v=%b e=%b i=%h want v=1 e=1 i=0",
                     b_rsp_valid, b_rsp_err, b_rsp_instr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_wr_collision();
        test_base();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
